// File: rtl/rr_arbiter_encoded.sv
// Round-robin arbiter for 2**N requesters: locks a binary-coded winner until
// the owner pulses done or an optional watchdog forces the grant free.
module rr_arbiter_encoded #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2**N-1:0]   req,
    input  logic              done,
    output logic              grant_valid,
    output logic [N-1:0]      grant_code,
    output logic              timeout
);

    localparam int REQ_W = 2**N;
    // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      ptr_q, ptr_d;
    logic [N-1:0]      grant_code_q, grant_code_d;
    logic              grant_valid_q, grant_valid_d;
    logic              timeout_q, timeout_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

    logic [REQ_W-1:0]  req_rot;
    logic [N-1:0]      win_off;
    logic              win_found;

    // req_rot[k] is the request that sits k places after the pointer.
    for (genvar gi = 0; gi < REQ_W; gi++) begin : g_rot
        assign req_rot[gi] = req[ptr_q + N'(gi)];
    end

    always_comb begin
        win_found = 1'b0;
        win_off   = '0;
        for (int i = REQ_W - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_found = 1'b1;
                win_off   = N'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_code_d  = grant_code_q;
        grant_valid_d = grant_valid_q;
        wd_cnt_d      = wd_cnt_q;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_code_d  = ptr_q + win_off;
                    grant_valid_d = 1'b1;
                    wd_cnt_d      = '0;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    ptr_d         = grant_code_q + N'(1);
                end else if ((TIMEOUT != 0) && (wd_cnt_q == WD_LAST)) begin
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    ptr_d         = grant_code_q + N'(1);
                    timeout_d     = 1'b1;
                end else if (TIMEOUT != 0) begin
                    wd_cnt_d      = wd_cnt_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_code_q  <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            wd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_code_q  <= grant_code_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_code  = grant_code_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_encoded.sv
// Bench for rr_arbiter_encoded: a watchdog instance (TIMEOUT=8) and a no-watchdog
// instance (TIMEOUT=0) share stimulus; each is compared every cycle to its own model.
module tb_rr_arbiter_encoded;

    localparam int N   = 4;
    localparam int NR  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic          done = 1'b0;

    logic          gv8, to8, gv0, to0;
    logic [N-1:0]  gc8, gc0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_encoded #(.N(N), .TIMEOUT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant_valid(gv8), .grant_code(gc8), .timeout(to8)
    );

    rr_arbiter_encoded #(.N(N), .TIMEOUT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant_valid(gv0), .grant_code(gc0), .timeout(to0)
    );

    // Reference model: 'held' counts cycles the current grant has been visible.
    typedef struct {
        bit busy;
        int owner;
        int ptr;
        int held;
        bit to;
    } mdl_t;

    mdl_t m8, m0;

    function automatic mdl_t mreset();
        mdl_t s;
        s.busy = 0; s.owner = 0; s.ptr = 0; s.held = 0; s.to = 0;
        return s;
    endfunction

    function automatic mdl_t mstep(mdl_t s, logic [NR-1:0] r, logic d, int tmo);
        mdl_t n = s;
        bit found = 0;
        n.to = 0;
        if (!s.busy) begin
            for (int k = 0; k < NR; k++) begin
                int idx = (s.ptr + k) % NR;
                if (!found && r[idx]) begin
                    found   = 1;
                    n.owner = idx;
                    n.busy  = 1;
                    n.held  = 1;
                end
            end
        end else if (d) begin
            n.busy = 0;
            n.ptr  = (s.owner + 1) % NR;
        end else if (tmo != 0 && s.held == tmo) begin
            n.busy = 0;
            n.ptr  = (s.owner + 1) % NR;
            n.to   = 1;
        end else begin
            n.held = s.held + 1;
        end
        return n;
    endfunction

    initial begin
        m8 = mreset();
        m0 = mreset();
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8 <= mreset();
            m0 <= mreset();
        end else begin
            m8 <= mstep(m8, req, done, 8);
            m0 <= mstep(m0, req, done, 0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("gv8",   int'(gv8), int'(m8.busy));
        chk("code8", int'(gc8), m8.owner);
        chk("to8",   int'(to8), int'(m8.to));
        chk("gv0",   int'(gv0), int'(m0.busy));
        chk("code0", int'(gc0), m0.owner);
        chk("to0",   int'(to0), int'(m0.to));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int cnt;
        bit saw_to;

        // Reset state
        #2;
        chk("rst_gv", int'(gv8), 0);
        chk("rst_code", int'(gc8), 0);
        do_reset();

        // 1: asynchronous reset in the middle of a grant
        req = 16'h0080;
        step();
        chk("t1_code7", int'(gc8), 7);
        req = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("t1_async_gv", int'(gv8), 0);
        chk("t1_async_code", int'(gc8), 0);
        step();
        rst_n = 1'b1;
        req = 16'h0001;
        step();
        chk("t1_after_gv", int'(gv8), 1);
        chk("t1_after_code", int'(gc8), 0);
        $display("t1 reset: code after release %0d", gc8);
        do_reset();

        // 2: single requester, then 4: pointer continuation
        req = 16'h0020;
        step();
        chk("t2_gv", int'(gv8), 1);
        chk("t2_code", int'(gc8), 5);
        req = '0; done = 1'b1;
        step();
        done = 1'b0;
        chk("t2_release", int'(gv8), 0);
        chk("t2_ptr", m8.ptr, 6);
        $display("t2 single: granted 5, ptr %0d", m8.ptr);
        req = 16'h0208;
        step();
        chk("t4_code9", int'(gc8), 9);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk("t4_code3", int'(gc8), 3);
        done = 1'b1; req = '0;
        step();
        done = 1'b0;
        chk("t4_ptr", m8.ptr, 4);
        $display("t4 pointer: 9 then 3, ptr %0d", m8.ptr);
        do_reset();

        // 3: full rotation with a bubble between grants
        req = 16'hFFFF;
        for (int g = 0; g <= NR; g++) begin
            step();
            chk("t3_code", int'(gc8), g % NR);
            step();
            done = 1'b1;
            step();
            done = 1'b0;
            chk("t3_bubble", int'(gv8), 0);
            $display("t3 rotation: grant %0d code %0d", g, g % NR);
        end
        req = '0;
        do_reset();

        // 5: watchdog release, then done on the last cycle beats the watchdog
        req = 16'h0004;
        step();
        req = '0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!gv8) break;
            cnt++;
            step();
        end
        chk("t5_high_cycles", cnt, 8);
        chk("t5_timeout", int'(to8), 1);
        chk("t5_ptr", m8.ptr, 3);
        step();
        chk("t5_timeout_pulse", int'(to8), 0);
        $display("t5 watchdog: held %0d cycles, ptr %0d", cnt, m8.ptr);
        req = 16'h0004;
        step();
        req = '0;
        chk("t5_regrant", int'(gc8), 2);
        for (int i = 0; i < 7; i++) step();
        chk("t5_cycle8_gv", int'(gv8), 1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("t5_done_gv", int'(gv8), 0);
        chk("t5_done_to", int'(to8), 0);
        $display("t5 done on cycle 8: timeout %0d", to8);
        do_reset();

        // 6: corner cases
        done = 1'b1;
        step();
        done = 1'b0;
        chk("t6_idle_done", int'(gv8), 0);
        req = 16'h0010;
        step();
        req = '0;
        cnt = 0;
        saw_to = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (gv0) cnt++;
            if (to0) saw_to = 1;
        end
        chk("t6_hold120", cnt, 120);
        chk("t6_no_timeout", int'(saw_to), 0);
        chk("t6_code0", int'(gc0), 4);
        $display("t6 no-watchdog: held %0d cycles, timeout seen %0d", cnt, saw_to);
        done = 1'b1;
        step();
        done = 1'b0;
        do_reset();

        // Randomised traffic, including occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: req = '0;
                1: req = 16'(1) << $urandom_range(0, NR - 1);
                2: req = 16'($urandom);
                default: req = 16'hFFFF;
            endcase
            if (i < 1500) done = ($urandom_range(0, 3) == 0);
            else          done = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            step();
        end
        req = '0; done = 1'b0;
        step();
        $display("random phase: 3000 cycles applied");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
